inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Streaming RV32I instruction encoder, the inverse of the immediate/field decode: takes kind, regs, funct, imm; emits 32-bit words.
//  Feeds the instruction-memory preload and self-test path; valid/ready on both sides, registered output.
//  Expands pseudo LI into LUI+ADDI (two words) through a small FSM; flags out-of-range immediates.
// PARAMETERS
//  ERR_WORD  32'h0000_0013  word emitted for illegal kind (ADDI x0,x0,0)
//  CHK_RANGE 1              1: drive out_err on range/alignment faults; 0: out_err tied 0
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   async, active-low; 0 clears all state
//  in_valid   in   1   request present
//  in_ready   out  1   encoder accepts request this cycle
//  in_kind    in   4   0 R,1 LOAD,2 JALR,3 OPIMM,4 STORE,5 BRANCH,6 LUI,7 AUIPC,8 JAL,9 LI,10-15 illegal
//  in_rd      in   5   destination reg
//  in_rs1     in   5   source reg 1
//  in_rs2     in   5   source reg 2
//  in_funct3  in   3   funct3 (ignored for U/J/LI)
//  in_funct7  in   7   funct7 (R only; OPIMM shifts take it from imm[11:5])
//  in_imm     in   32  full signed byte value (U: final value, low 12 bits expected 0)
//  out_valid  out  1   out_inst valid
//  out_ready  in   1   consumer accepts word
//  out_inst   out  32  encoded instruction
//  out_err    out  1   qualifies out_inst: immediate fault or illegal kind
// BEHAVIOUR
//  Opcodes: R 0110011, LOAD 0000011, JALR 1100111, OPIMM 0010011, STORE 0100011,
//   BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111.
//  Fields: I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op};
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op};
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; R {f7,rs2,rs1,f3,rd,op}.
//  Range faults (out_err=1, word still emitted from truncated fields):
//   I/S imm outside [-2048,2047]; B outside [-4096,4094] or imm[0]=1;
//   J outside [-2^20,2^20-2] or imm[0]=1; U imm[11:0]!=0. R/LI never fault. Illegal kind: ERR_WORD, err=1.
//  FSM states: IDLE (out empty), HOLD (one word held), HOLD2 (LI low word pending).
//   IDLE: in_ready=1; accept -> HOLD.
//   HOLD: in_ready=out_ready; if out_ready & in_valid -> reload, stay HOLD (1 word/clk);
//         out_ready & !in_valid -> IDLE; !out_ready -> hold out_* stable.
//   LI accept: lo=sext(imm[11:0]); if imm==lo: single ADDI rd,x0,lo -> HOLD.
//    else word1 LUI rd,(imm+0x800)[31:12] -> HOLD2, latch rd and lo.
//   HOLD2: in_ready=0; on out_ready emit ADDI rd,rd,lo -> HOLD. Skip none: ADDI sent even if lo=0.
//  Latency: request accepted at edge N -> out_valid at N+1 (registered, no comb in->out path).
//  out_* stable while out_valid & !out_ready. in_ready never depends on in_valid.
//  Arithmetic: imm+0x800 is 32-bit wrap (0x7FFFF800..0x7FFFFFFF wraps to 0x80000 hi, correct mod 2^32).
//  Reset: out_valid=0, out_inst=0, out_err=0, in_ready=0 during reset, state IDLE; asserting reset
//   mid-LI drops the pending ADDI; first cycle after release in_ready=1.
// TESTING
//  T1 kind3 rd5 rs1 0 f3 0 imm -1 -> out_inst 0xFFF00293, err 0, one cycle later.
//  T2 kind4 rs1 1 rs2 2 f3 010 imm 8 -> 0x0020A423; kind5 rs1 1 rs2 2 f3 0 imm 8 -> 0x00208463;
//     same B with imm 7 -> err 1.
//  T3 kind8 rd1 imm 0x800 -> 0x001000EF; imm 0x100000 -> err 1.
//  T4 kind9 rd10 imm 0x12345FFF -> 0x12346537 then 0xFFF50513, in_ready 0 between;
//     imm 5 -> single 0x00500513.
//  T5 back-to-back 8 OPIMM with out_ready=1 -> 8 words in 8 clks; random out_ready stalls -> no loss/dup, out stable.
//  T6 reset low after LUI of LI emitted -> out_valid 0, no ADDI after release; kind 12 -> ERR_WORD, err 1.

Source files
------------

// File: rtl/inst_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master side issues encode requests and consumes encoded words;
// the slave side is the encoder itself.
interface inst_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_kind;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;

   modport master (
      output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_err
   );

   modport slave (
      input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_err
   );
endinterface

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: turns (kind, regs, funct, imm) into
// 32-bit instruction words, one registered word per accepted request.
// Pseudo LI is expanded into LUI+ADDI when the value does not fit in 12 bits.
// Immediates that cannot be represented raise out_err alongside the word.
module inst_encoder #(
   parameter logic [31:0] ERR_WORD  = 32'h0000_0013,
   parameter bit          CHK_RANGE = 1'b1
) (
   input logic           clk,
   input logic           reset,
   inst_encoder_if.slave bus
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [3:0] K_R      = 4'd0;
   localparam logic [3:0] K_LOAD   = 4'd1;
   localparam logic [3:0] K_JALR   = 4'd2;
   localparam logic [3:0] K_OPIMM  = 4'd3;
   localparam logic [3:0] K_STORE  = 4'd4;
   localparam logic [3:0] K_BRANCH = 4'd5;
   localparam logic [3:0] K_LUI    = 4'd6;
   localparam logic [3:0] K_AUIPC  = 4'd7;
   localparam logic [3:0] K_JAL    = 4'd8;
   localparam logic [3:0] K_LI     = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      HOLD2 = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] outInst_q;
   logic        outErr_q;
   logic [4:0]  liRd_q;
   logic [11:0] liLo_q;

   logic [31:0] encWord;
   logic        encErr;
   logic        encSplit;
   logic        fitsI, fitsB, fitsJ;
   logic [19:0] liHi;
   logic        accept;
   logic        drainLo;

   // An immediate fits a signed N-bit field when all bits above it are sign copies.
   assign fitsI = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
   assign fitsB = (&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12]);
   assign fitsJ = (&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20]);

   // Upper part of LI rounded so that the sign-extended low 12 bits add back exactly;
   // adding imm[11] to imm[31:12] equals (imm + 0x800)[31:12] with the same 32-bit wrap.
   assign liHi = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};

   assign accept  = bus.in_valid & bus.in_ready;
   assign drainLo = (state_q == HOLD2) & bus.out_ready;

   // Combinational field packing and range checking for the current request.
   always_comb begin
      encWord  = ERR_WORD;
      encErr   = 1'b1;
      encSplit = 1'b0;
      unique case (bus.in_kind)
         K_R: begin
            encWord = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_R};
            encErr  = 1'b0;
         end
         K_LOAD: begin
            encWord = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
            encErr  = ~fitsI;
         end
         K_JALR: begin
            encWord = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_JALR};
            encErr  = ~fitsI;
         end
         K_OPIMM: begin
            encWord = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_OPIMM};
            encErr  = ~fitsI;
         end
         K_STORE: begin
            encWord = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_imm[4:0], OP_STORE};
            encErr  = ~fitsI;
         end
         K_BRANCH: begin
            encWord = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
            encErr  = ~fitsB | bus.in_imm[0];
         end
         K_LUI: begin
            encWord = {bus.in_imm[31:12], bus.in_rd, OP_LUI};
            encErr  = |bus.in_imm[11:0];
         end
         K_AUIPC: begin
            encWord = {bus.in_imm[31:12], bus.in_rd, OP_AUIPC};
            encErr  = |bus.in_imm[11:0];
         end
         K_JAL: begin
            encWord = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                       bus.in_rd, OP_JAL};
            encErr  = ~fitsJ | bus.in_imm[0];
         end
         K_LI: begin
            encErr = 1'b0;
            if (fitsI) begin
               encWord = {bus.in_imm[11:0], 5'd0, 3'b000, bus.in_rd, OP_OPIMM};
            end else begin
               encWord  = {liHi, bus.in_rd, OP_LUI};
               encSplit = 1'b1;
            end
         end
         default: begin
            encWord = ERR_WORD;
            encErr  = 1'b1;
         end
      endcase
      encErr = encErr & CHK_RANGE;
   end

   // State register; reset abandons any pending LI low half.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a held word leaves on out_ready, a new request may replace it in the same clock.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = encSplit ? HOLD2 : HOLD;
            end
         end
         HOLD: begin
            if (accept) begin
               state_d = encSplit ? HOLD2 : HOLD;
            end else if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         HOLD2: begin
            if (bus.out_ready) begin
               state_d = HOLD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from state only, so in_ready never looks at in_valid.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = reset;
         end
         HOLD: begin
            bus.in_ready  = reset & bus.out_ready;
            bus.out_valid = 1'b1;
         end
         HOLD2: begin
            bus.out_valid = 1'b1;
         end
         default: begin
            bus.in_ready  = 1'b0;
            bus.out_valid = 1'b0;
         end
      endcase
   end

   // Output word register plus the LI low half kept for the follow-up ADDI.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outInst_q <= 32'd0;
         outErr_q  <= 1'b0;
         liRd_q    <= 5'd0;
         liLo_q    <= 12'd0;
      end else if (accept) begin
         outInst_q <= encWord;
         outErr_q  <= encErr;
         liRd_q    <= bus.in_rd;
         liLo_q    <= bus.in_imm[11:0];
      end else if (drainLo) begin
         outInst_q <= {liLo_q, liRd_q, 3'b000, liRd_q, OP_OPIMM};
         outErr_q  <= 1'b0;
      end
   end

   assign bus.out_inst = outInst_q;
   assign bus.out_err  = outErr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed encodings with known words,
// LI expansion, back-to-back streaming, random stalls against a reference model,
// and reset in the middle of an LI pair.
module tb_inst_encoder;

   localparam logic [31:0] ERR_WORD = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   inst_encoder_if bus();

   inst_encoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  kind;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } req_t;

   typedef struct {
      req_t        r;
      logic [31:0] w;
      bit          chkW;
      logic        e;
      string       name;
   } vec_t;

   logic [32:0] expQ[$];

   function automatic req_t mk(input int kind, input int rd, input int rs1, input int rs2,
                               input int f3, input int f7, input logic [31:0] imm);
      req_t r;
      r.kind = 4'(kind);
      r.rd   = 5'(rd);
      r.rs1  = 5'(rs1);
      r.rs2  = 5'(rs2);
      r.f3   = 3'(f3);
      r.f7   = 7'(f7);
      r.imm  = imm;
      return r;
   endfunction

   function automatic vec_t mkv(input req_t r, input logic [31:0] w, input bit chkW,
                                input logic e, input string name);
      vec_t v;
      v.r    = r;
      v.w    = w;
      v.chkW = chkW;
      v.e    = e;
      v.name = name;
      return v;
   endfunction

   // Reference model: range limits as signed integer comparisons, LI split via
   // the signed low part and the exact remainder.
   function automatic void model(input req_t r, output int n, output logic [31:0] w0,
                                 output logic [31:0] w1, output logic e);
      int          s;
      int          lo;
      logic [31:0] loW;
      logic [31:0] diff;
      s  = r.imm;
      n  = 1;
      w1 = 32'd0;
      e  = 1'b0;
      case (r.kind)
         4'd0: w0 = {r.f7, r.rs2, r.rs1, r.f3, r.rd, 7'b0110011};
         4'd1, 4'd2, 4'd3: begin
            w0 = {r.imm[11:0], r.rs1, r.f3, r.rd,
                  (r.kind == 4'd1) ? 7'b0000011 : (r.kind == 4'd2) ? 7'b1100111 : 7'b0010011};
            e  = (s < -2048) || (s > 2047);
         end
         4'd4: begin
            w0 = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], 7'b0100011};
            e  = (s < -2048) || (s > 2047);
         end
         4'd5: begin
            w0 = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], 7'b1100011};
            e  = (s < -4096) || (s > 4094) || ((s & 1) != 0);
         end
         4'd6, 4'd7: begin
            w0 = {r.imm[31:12], r.rd, (r.kind == 4'd6) ? 7'b0110111 : 7'b0010111};
            e  = (r.imm & 32'hFFF) != 32'd0;
         end
         4'd8: begin
            w0 = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, 7'b1101111};
            e  = (s < -1048576) || (s > 1048574) || ((s & 1) != 0);
         end
         4'd9: begin
            lo = {20'd0, r.imm[11:0]};
            if (lo >= 2048) lo = lo - 4096;
            loW = lo;
            if (lo == s) begin
               w0 = {loW[11:0], 5'd0, 3'b000, r.rd, 7'b0010011};
            end else begin
               diff = r.imm - loW;
               n    = 2;
               w0   = {diff[31:12], r.rd, 7'b0110111};
               w1   = {loW[11:0], r.rd, 3'b000, r.rd, 7'b0010011};
            end
         end
         default: begin
            w0 = ERR_WORD;
            e  = 1'b1;
         end
      endcase
   endfunction

   function automatic req_t rand_req();
      req_t        r;
      logic [31:0] bnd [14];
      bnd = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd4094, 32'd4095,
              32'd4096, 32'hFFFF_F000, 32'hFFFF_EFFE, 32'd1048574, 32'd1048576,
              32'hFFF0_0000, 32'h7FFF_F800, 32'h7FFF_FFFF};
      r.kind = 4'($urandom_range(0, 15));
      r.rd   = 5'($urandom);
      r.rs1  = 5'($urandom);
      r.rs2  = 5'($urandom);
      r.f3   = 3'($urandom);
      r.f7   = 7'($urandom);
      case ($urandom_range(0, 4))
         0:       r.imm = $urandom;
         1:       r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
         2:       r.imm = bnd[$urandom_range(0, 13)];
         3:       r.imm = $urandom & 32'hFFFF_F000;
         default: r.imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      return r;
   endfunction

   task automatic drive_idle();
      bus.in_valid  = 1'b0;
      bus.in_kind   = 4'd0;
      bus.in_rd     = 5'd0;
      bus.in_rs1    = 5'd0;
      bus.in_rs2    = 5'd0;
      bus.in_funct3 = 3'd0;
      bus.in_funct7 = 7'd0;
      bus.in_imm    = 32'd0;
   endtask

   task automatic set_req(input req_t r);
      bus.in_valid  = 1'b1;
      bus.in_kind   = r.kind;
      bus.in_rd     = r.rd;
      bus.in_rs1    = r.rs1;
      bus.in_rs2    = r.rs2;
      bus.in_funct3 = r.f3;
      bus.in_funct7 = r.f7;
      bus.in_imm    = r.imm;
   endtask

   // Present one request from a falling edge and return on the falling edge after it is taken.
   task automatic send_one(input req_t r);
      bit acc;
      acc = 1'b0;
      set_req(r);
      for (int k = 0; k < 20 && !acc; k++) begin
         #1;
         acc = bus.in_ready;
         @(posedge clk);
         @(negedge clk);
      end
      drive_idle();
      if (!acc) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_timeout in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive_idle();
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'd0 || bus.out_err !== 1'b0 ||
          bus.in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state valid=%b inst=%h err=%b rdy=%b want 0 00000000 0 0",
                  bus.out_valid, bus.out_inst, bus.out_err, bus.in_ready);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_itype();
      vec_t v[7];
      bus.out_ready = 1'b1;
      @(negedge clk);
      v[0] = mkv(mk(3, 5, 0, 0, 0, 0, 32'hFFFF_FFFF), 32'hFFF0_0293, 1, 0, "t1_addi_m1");
      v[1] = mkv(mk(1, 1, 2, 0, 2, 0, 32'd2047), 32'h7FF1_2083, 1, 0, "load_2047");
      v[2] = mkv(mk(1, 1, 2, 0, 2, 0, 32'd2048), 32'd0, 0, 1, "load_2048");
      v[3] = mkv(mk(2, 1, 2, 0, 0, 0, 32'hFFFF_F800), 32'd0, 0, 0, "jalr_m2048");
      v[4] = mkv(mk(3, 1, 2, 0, 0, 0, 32'hFFFF_F7FF), 32'd0, 0, 1, "addi_m2049");
      v[5] = mkv(mk(0, 3, 1, 2, 0, 32, 32'hFFFF_FFFF), 32'h4020_81B3, 1, 0, "r_sub");
      v[6] = mkv(mk(12, 3, 1, 2, 0, 0, 32'd0), ERR_WORD, 1, 1, "illegal_k12");
      foreach (v[i]) begin
         send_one(v[i].r);
         checks++;
         if (bus.out_valid !== 1'b1 || (v[i].chkW && bus.out_inst !== v[i].w) ||
             bus.out_err !== v[i].e) begin
            errors++;
            $display("[TB] FAIL %s valid=%b inst=%h err=%b want 1 %h %b", v[i].name,
                     bus.out_valid, bus.out_inst, bus.out_err, v[i].w, v[i].e);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL itype_drain valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_store_branch();
      vec_t v[6];
      bus.out_ready = 1'b1;
      @(negedge clk);
      v[0] = mkv(mk(4, 0, 1, 2, 2, 0, 32'd8), 32'h0020_A423, 1, 0, "t2_sw");
      v[1] = mkv(mk(5, 0, 1, 2, 0, 0, 32'd8), 32'h0020_8463, 1, 0, "t2_beq");
      v[2] = mkv(mk(5, 0, 1, 2, 0, 0, 32'd7), 32'd0, 0, 1, "t2_beq_odd");
      v[3] = mkv(mk(5, 0, 1, 2, 0, 0, 32'd4094), 32'd0, 0, 0, "beq_4094");
      v[4] = mkv(mk(5, 0, 1, 2, 0, 0, 32'd4096), 32'd0, 0, 1, "beq_4096");
      v[5] = mkv(mk(4, 0, 1, 2, 2, 0, 32'd2048), 32'd0, 0, 1, "sw_2048");
      foreach (v[i]) begin
         send_one(v[i].r);
         checks++;
         if (bus.out_valid !== 1'b1 || (v[i].chkW && bus.out_inst !== v[i].w) ||
             bus.out_err !== v[i].e) begin
            errors++;
            $display("[TB] FAIL %s valid=%b inst=%h err=%b want 1 %h %b", v[i].name,
                     bus.out_valid, bus.out_inst, bus.out_err, v[i].w, v[i].e);
         end
      end
   endtask

   task automatic test_jal_lui();
      vec_t v[6];
      bus.out_ready = 1'b1;
      @(negedge clk);
      v[0] = mkv(mk(8, 1, 0, 0, 0, 0, 32'h0000_0800), 32'h0010_00EF, 1, 0, "t3_jal");
      v[1] = mkv(mk(8, 1, 0, 0, 0, 0, 32'h0010_0000), 32'd0, 0, 1, "t3_jal_far");
      v[2] = mkv(mk(8, 1, 0, 0, 0, 0, 32'hFFF0_0000), 32'd0, 0, 0, "jal_min");
      v[3] = mkv(mk(6, 3, 0, 0, 0, 0, 32'hABCD_E000), 32'hABCD_E1B7, 1, 0, "lui");
      v[4] = mkv(mk(6, 3, 0, 0, 0, 0, 32'h0000_0001), 32'd0, 0, 1, "lui_low");
      v[5] = mkv(mk(7, 2, 0, 0, 0, 0, 32'h0000_1000), 32'h0000_1117, 1, 0, "auipc");
      foreach (v[i]) begin
         send_one(v[i].r);
         checks++;
         if (bus.out_valid !== 1'b1 || (v[i].chkW && bus.out_inst !== v[i].w) ||
             bus.out_err !== v[i].e) begin
            errors++;
            $display("[TB] FAIL %s valid=%b inst=%h err=%b want 1 %h %b", v[i].name,
                     bus.out_valid, bus.out_inst, bus.out_err, v[i].w, v[i].e);
         end
      end
   endtask

   task automatic test_li();
      logic [31:0] imms [2];
      logic [31:0] hiW [2];
      imms = '{32'h1234_5FFF, 32'h7FFF_FFFF};
      hiW  = '{32'h1234_6537, 32'h8000_0537};
      bus.out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         send_one(mk(9, 10, 0, 0, 0, 0, imms[i]));
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_inst !== hiW[i] || bus.out_err !== 1'b0 ||
             bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL li_lui valid=%b inst=%h err=%b rdy=%b want 1 %h 0 0",
                     bus.out_valid, bus.out_inst, bus.out_err, bus.in_ready, hiW[i]);
         end
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'hFFF5_0513 || bus.out_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL li_addi valid=%b inst=%h err=%b want 1 fff50513 0",
                     bus.out_valid, bus.out_inst, bus.out_err);
         end
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL li_end valid got %b want 0", bus.out_valid);
         end
      end
      send_one(mk(9, 10, 0, 0, 0, 0, 32'd5));
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h0050_0513 || bus.out_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL li_small valid=%b inst=%h err=%b want 1 00500513 0",
                  bus.out_valid, bus.out_inst, bus.out_err);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL li_small_single valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      req_t        r[8];
      logic [31:0] w[8];
      logic [31:0] w1;
      logic        e;
      int          n;
      for (int i = 0; i < 8; i++) begin
         r[i] = mk(3, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0,
                   int'($urandom_range(0, 7)), 0, 32'($urandom_range(0, 4095)) - 32'd2048);
         model(r[i], n, w[i], w1, e);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_inst !== w[i-1]) begin
               errors++;
               $display("[TB] FAIL b2b_word%0d valid=%b inst=%h want 1 %h", i - 1,
                        bus.out_valid, bus.out_inst, w[i-1]);
            end
         end
         if (i < 8) begin
            set_req(r[i]);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
               errors++;
               $display("[TB] FAIL b2b_ready%0d got %b want 1", i, bus.in_ready);
            end
         end else begin
            drive_idle();
         end
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_drain valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_random_stall();
      localparam int NREQ = 200;
      req_t        r;
      int          sent;
      int          cyc;
      bit          held;
      bit          taken;
      logic [32:0] heldVal;
      logic [32:0] exp;
      logic [31:0] w0, w1;
      logic        e;
      int          n;
      sent  = 0;
      cyc   = 0;
      held  = 1'b0;
      taken = 1'b0;
      r     = mk(0, 0, 0, 0, 0, 0, 32'd0);
      expQ.delete();
      drive_idle();
      while ((sent < NREQ || expQ.size() != 0 || bus.out_valid === 1'b1) && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (held) begin
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_err, bus.out_inst} !== heldVal) begin
               errors++;
               $display("[TB] FAIL stall_stable valid=%b word=%h want 1 %h",
                        bus.out_valid, {bus.out_err, bus.out_inst}, heldVal);
            end
         end
         if (taken) begin
            drive_idle();
            taken = 1'b0;
         end
         if (bus.in_valid !== 1'b1 && sent < NREQ && $urandom_range(0, 3) != 0) begin
            r = rand_req();
            set_req(r);
         end
         bus.out_ready = ($urandom_range(0, 2) != 0);
         #1;
         held    = (bus.out_valid === 1'b1) && !bus.out_ready;
         heldVal = {bus.out_err, bus.out_inst};
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL stall_extra word=%h want none", heldVal);
            end else begin
               exp = expQ.pop_front();
               if (heldVal !== exp) begin
                  errors++;
                  $display("[TB] FAIL stall_word got %h want %h", heldVal, exp);
               end
            end
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            model(r, n, w0, w1, e);
            expQ.push_back({e, w0});
            if (n == 2) expQ.push_back({1'b0, w1});
            sent++;
            taken = 1'b1;
         end
      end
      drive_idle();
      checks++;
      if (sent != NREQ || expQ.size() != 0 || cyc >= 6000) begin
         errors++;
         $display("[TB] FAIL stall_complete sent=%0d left=%0d cycles=%0d want %0d 0 <6000",
                  sent, expQ.size(), cyc, NREQ);
      end
   endtask

   task automatic test_reset_mid_li();
      bus.out_ready = 1'b1;
      @(negedge clk);
      send_one(mk(9, 10, 0, 0, 0, 0, 32'h1234_5FFF));
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'd0 || bus.out_err !== 1'b0 ||
          bus.in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midli_reset valid=%b inst=%h err=%b rdy=%b want 0 00000000 0 0",
                  bus.out_valid, bus.out_inst, bus.out_err, bus.in_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midli_release_ready got %b want 1", bus.in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midli_no_addi cycle %0d valid=%b inst=%h want 0",
                     i, bus.out_valid, bus.out_inst);
         end
      end
   endtask

   // Upper bound on total run time in case the design stops handshaking entirely.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog run did not complete");
      $fatal(1, "[TB] watchdog");
   end

   // Test sequence.
   initial begin
      reset = 1'b0;
      drive_idle();
      bus.out_ready = 1'b0;
      test_reset();
      test_itype();
      test_store_branch();
      test_jal_lui();
      test_li();
      test_back_to_back();
      test_random_stall();
      test_reset_mid_li();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
